// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, imem request/ack handshake, instruction register and field slicing
// Branch redirects during an in-flight request drain the stale response before the target is fetched.
module instr_fetch_unit #(
  parameter int PC_WIDTH    = 12,
  parameter int INSTR_WIDTH = 19
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   enablePC,
  input  logic                   stall,
  input  logic                   branchTaken,
  input  logic [PC_WIDTH-1:0]    branchTarget,
  output logic                   imemReq,
  output logic [PC_WIDTH-1:0]    imemAddr,
  input  logic                   imemAck,
  input  logic [INSTR_WIDTH-1:0] imemData,
  output logic                   instrValid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [PC_WIDTH-1:0]    pcPlus1,
  output logic [1:0]             lasttwoBits,
  output logic [2:0]             lastthreeBits,
  output logic [2:0]             threeBitFn,
  output logic [1:0]             twoBitFn,
  output logic [2:0]             ri1,
  output logic [2:0]             ri2,
  output logic [2:0]             ri3,
  output logic [7:0]             imm
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]    req_addr_q, req_addr_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   instr_valid_q, instr_valid_d;
  logic                   imem_req_q, imem_req_d;
  logic                   consume;

  assign consume = instr_valid_q & enablePC & ~stall & ~branchTaken;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    req_addr_d    = req_addr_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    unique case (state_q)
      S_IDLE: begin
        state_d    = S_FETCH;
        req_addr_d = fetch_pc_q;
      end
      S_FETCH: begin
        if (branchTaken) begin
          fetch_pc_d = branchTarget;
          if (imemAck) begin
            req_addr_d = branchTarget;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (imemAck) begin
          instr_d       = imemData;
          pc_d          = req_addr_q;
          instr_valid_d = 1'b1;
          fetch_pc_d    = req_addr_q + PC_ONE;
          state_d       = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (branchTaken) begin
          fetch_pc_d = branchTarget;
        end
        // A redirect landing on the drain ack cycle must win over the older target.
        if (imemAck) begin
          req_addr_d = branchTaken ? branchTarget : fetch_pc_q;
          state_d    = S_FETCH;
        end
      end
      S_ISSUE: begin
        if (branchTaken) begin
          instr_valid_d = 1'b0;
          fetch_pc_d    = branchTarget;
          req_addr_d    = branchTarget;
          state_d       = S_FETCH;
        end else if (consume) begin
          instr_valid_d = 1'b0;
          req_addr_d    = fetch_pc_q;
          state_d       = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
    imem_req_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= '0;
      req_addr_q    <= '0;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      req_addr_q    <= req_addr_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
    end
  end

  assign imemReq       = imem_req_q;
  assign imemAddr      = req_addr_q;
  assign instrValid    = instr_valid_q;
  assign instr         = instr_q;
  assign pc            = pc_q;
  assign pcPlus1       = pc_q + PC_ONE;
  assign lasttwoBits   = instr_q[18:17];
  assign lastthreeBits = instr_q[18:16];
  assign threeBitFn    = instr_q[16:14];
  assign twoBitFn      = instr_q[15:14];
  assign ri1           = instr_q[13:11];
  assign ri2           = instr_q[10:8];
  assign ri3           = instr_q[7:5];
  assign imm           = instr_q[7:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed plus randomized bench for instr_fetch_unit
// The reference tracks transactions (outstanding request, stale response, held instruction), not FSM states.
module tb_instr_fetch_unit;

  logic        clock;
  logic        rst;
  logic        enablePC;
  logic        stall;
  logic        branchTaken;
  logic [11:0] branchTarget;
  logic        imemReq;
  logic [11:0] imemAddr;
  logic        imemAck;
  logic [18:0] imemData;
  logic        instrValid;
  logic [18:0] instr;
  logic [11:0] pc;
  logic [11:0] pcPlus1;
  logic [1:0]  lasttwoBits;
  logic [2:0]  lastthreeBits;
  logic [2:0]  threeBitFn;
  logic [1:0]  twoBitFn;
  logic [2:0]  ri1;
  logic [2:0]  ri2;
  logic [2:0]  ri3;
  logic [7:0]  imm;

  instr_fetch_unit #(.PC_WIDTH(12), .INSTR_WIDTH(19)) dut (
    .clock(clock), .rst(rst), .enablePC(enablePC), .stall(stall),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .instrValid(instrValid), .instr(instr), .pc(pc), .pcPlus1(pcPlus1),
    .lasttwoBits(lasttwoBits), .lastthreeBits(lastthreeBits),
    .threeBitFn(threeBitFn), .twoBitFn(twoBitFn),
    .ri1(ri1), .ri2(ri2), .ri3(ri3), .imm(imm)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic        force_en   = 1'b0;
  logic [18:0] force_val  = '0;
  int          data_mode  = 0;

  bit          m_idle, m_busy, m_stale, m_valid;
  logic [11:0] m_next, m_addr, m_pc;
  logic [18:0] m_instr;

  function automatic logic [18:0] data_fn(input logic [11:0] a);
    int unsigned h;
    if (force_en) return force_val;
    if (data_mode == 0) return {7'd0, a};
    h = (32'(a) * 32'd40503 + 32'd12345) ^ 32'h0002_B3C5;
    return h[18:0];
  endfunction

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic ack, input logic br, input logic [11:0] tgt,
                            input logic en, input logic st, input logic r);
    if (r) begin
      m_idle = 1; m_busy = 0; m_stale = 0; m_valid = 0;
      m_next = '0; m_addr = '0; m_pc = '0; m_instr = '0;
    end else if (m_idle) begin
      m_idle = 0; m_busy = 1; m_addr = m_next;
    end else if (m_busy) begin
      if (ack) begin
        if (m_stale || br) begin
          if (br) m_next = tgt;
          m_addr  = m_next;
          m_stale = 0;
        end else begin
          m_instr = data_fn(m_addr);
          m_pc    = m_addr;
          m_valid = 1;
          m_next  = m_addr + 12'd1;
          m_busy  = 0;
        end
      end else if (br) begin
        m_next  = tgt;
        m_stale = 1;
      end
    end else if (m_valid) begin
      if (br) begin
        m_valid = 0; m_next = tgt; m_addr = tgt; m_busy = 1;
      end else if (en && !st) begin
        m_valid = 0; m_addr = m_next; m_busy = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("imemReq", 19'(imemReq), 19'(m_busy));
    if (m_busy) chk("imemAddr", 19'(imemAddr), 19'(m_addr));
    chk("instrValid", 19'(instrValid), 19'(m_valid));
    chk("instr", instr, m_instr);
    chk("pc", 19'(pc), 19'(m_pc));
    chk("pcPlus1", 19'(pcPlus1), 19'((32'(m_pc) + 1) % 4096));
    chk("fields_hi", 19'({lasttwoBits, lastthreeBits, threeBitFn, twoBitFn}),
        19'({2'((m_instr >> 17) % 4), 3'((m_instr >> 16) % 8),
             3'((m_instr >> 14) % 8), 2'((m_instr >> 14) % 4)}));
    chk("fields_lo", 19'({ri1, ri2, ri3, imm}),
        19'({3'((m_instr >> 11) % 8), 3'((m_instr >> 8) % 8),
             3'((m_instr >> 5) % 8), 8'(m_instr % 256)}));
  endtask

  task automatic cycle(input logic ack, input logic br, input logic [11:0] tgt,
                       input logic en, input logic st, input logic r);
    imemAck      = ack;
    branchTaken  = br;
    branchTarget = tgt;
    enablePC     = en;
    stall        = st;
    rst          = r;
    imemData     = data_fn(imemAddr);
    @(posedge clock);
    model_edge(ack, br, tgt, en, st, r);
    #1;
    check_all();
  endtask

  initial begin
    imemAck = 0; branchTaken = 0; branchTarget = '0; enablePC = 0; stall = 0;
    rst = 1; imemData = '0;
    #1;

    cycle(0, 0, 12'h0, 0, 0, 1);
    cycle(0, 0, 12'h0, 0, 0, 1);
    chk("rst_req", 19'(imemReq), 19'd0);
    chk("rst_valid", 19'(instrValid), 19'd0);
    chk("rst_imm", 19'(imm), 19'd0);

    // zero-wait memory returning data = address
    cycle(0, 0, 12'h0, 0, 0, 0);
    chk("zw_first_req", 19'(imemReq), 19'd1);
    for (int i = 0; i < 3; i++) begin
      chk("zw_addr", 19'(imemAddr), 19'(i));
      cycle(1, 0, 12'h0, 0, 0, 0);
      chk("zw_valid", 19'(instrValid), 19'd1);
      chk("zw_instr", instr, 19'(i));
      chk("zw_pc", 19'(pc), 19'(i));
      cycle(0, 0, 12'h0, 1, 0, 0);
      chk("zw_valid_drop", 19'(instrValid), 19'd0);
    end

    // delayed ack after a fresh reset
    cycle(1, 0, 12'h0, 0, 0, 1);
    cycle(0, 0, 12'h0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 12'h0, 0, 0, 0);
      chk("dly_req", 19'(imemReq), 19'd1);
      chk("dly_addr", 19'(imemAddr), 19'd0);
      chk("dly_novalid", 19'(instrValid), 19'd0);
    end
    cycle(1, 0, 12'h0, 0, 0, 0);
    chk("dly_cap", 19'(instrValid), 19'd1);

    // stall hold in ISSUE
    force_en = 1; force_val = 19'h5A5A5;
    cycle(0, 0, 12'h0, 1, 0, 0);
    cycle(1, 0, 12'h0, 0, 0, 0);
    force_en = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(1, 0, 12'h0, 1, 1, 0);
      chk("stall_instr", instr, 19'h5A5A5);
      chk("stall_pc", 19'(pc), 19'd1);
      chk("stall_req", 19'(imemReq), 19'd0);
    end
    cycle(0, 0, 12'h0, 1, 0, 0);
    chk("stall_resume", 19'(imemAddr), 19'd2);

    // redirect during a delayed fetch of 004
    cycle(1, 0, 12'h0, 0, 0, 0);
    cycle(0, 0, 12'h0, 1, 0, 0);
    cycle(1, 0, 12'h0, 0, 0, 0);
    cycle(0, 0, 12'h0, 1, 0, 0);
    cycle(0, 0, 12'h0, 0, 0, 0);
    cycle(0, 1, 12'h100, 0, 0, 0);
    chk("drain_addr", 19'(imemAddr), 19'h004);
    cycle(0, 0, 12'h0, 0, 0, 0);
    chk("drain_hold", 19'(imemAddr), 19'h004);
    cycle(1, 0, 12'h0, 0, 0, 0);
    chk("drain_next", 19'(imemAddr), 19'h100);
    chk("drain_discard", 19'(instrValid), 19'd0);
    cycle(1, 0, 12'h0, 0, 0, 0);
    chk("redir_pc", 19'(pc), 19'h100);

    // branch with ack, branch with consume
    cycle(0, 0, 12'h0, 1, 0, 0);
    cycle(1, 1, 12'h200, 0, 0, 0);
    chk("br_ack_addr", 19'(imemAddr), 19'h200);
    chk("br_ack_nocap", 19'(instrValid), 19'd0);
    cycle(1, 0, 12'h0, 0, 0, 0);
    cycle(0, 1, 12'h300, 1, 0, 0);
    chk("br_cons_addr", 19'(imemAddr), 19'h300);
    cycle(1, 0, 12'h0, 0, 0, 0);
    chk("br_cons_pc", 19'(pc), 19'h300);

    // wrap at the top of the address space
    cycle(0, 1, 12'hFFF, 0, 0, 0);
    cycle(1, 0, 12'h0, 0, 0, 0);
    chk("wrap_plus1", 19'(pcPlus1), 19'd0);
    cycle(0, 0, 12'h0, 1, 0, 0);
    chk("wrap_addr", 19'(imemAddr), 19'h000);

    // reset during FETCH with a pending ack
    cycle(1, 0, 12'h0, 0, 0, 1);
    chk("midrst_req", 19'(imemReq), 19'd0);
    chk("midrst_valid", 19'(instrValid), 19'd0);
    cycle(0, 0, 12'h0, 0, 0, 0);
    chk("midrst_restart", 19'(imemAddr), 19'h000);

    // randomized traffic against the reference
    data_mode = 1;
    for (int n = 0; n < 600; n++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
            12'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
